fft_pair_buffer: RTL and testbench

Streaming radix-2 pairing stage that sits directly upstream of each FFT butterfly. It accepts one complex sample per cycle and buffers the first half of each DEPTH*2-sample frame. It then emits registered operand pairs (x[k], x[k+DEPTH]) on the butterfly's in0/in1 ports, together with the pair index k that downstream logic uses for twiddle selection.

---
 rtl/fft_pair_buffer.sv | 102 ++++++++++
 tb/tb_fft_pair_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fft_pair_buffer.sv
// Radix-2 pairing stage: buffers the first half of each 2*DEPTH frame and emits (x[k], x[k+DEPTH]) pairs.
// Optional macro FFT_PAIR_BUF_SCALE_EN adds a (x+1)>>>1 rounding halver at the output register.
module fft_pair_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_WIDTH-1:0]         real_in,
    input  logic [DATA_WIDTH-1:0]         imag_in,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         real_out0,
    output logic [DATA_WIDTH-1:0]         imag_out0,
    output logic [DATA_WIDTH-1:0]         real_out1,
    output logic [DATA_WIDTH-1:0]         imag_out1,
    output logic [$clog2(DEPTH)-1:0]      out_idx,
    output logic                          frame_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   mem_re [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_im [DEPTH];

    logic accept;
    logic sof_take;
    logic fill_take;
    logic pair_take;

    assign accept    = in_valid && en;
    assign sof_take  = accept && in_sof;
    assign fill_take = accept && !in_sof && (state == FILL);
    assign pair_take = accept && !in_sof && (state == PAIR);

    // Extra sign bit keeps +1 from overflowing at the positive full-scale value.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
`ifdef FFT_PAIR_BUF_SCALE_EN
        return DATA_WIDTH'(({x[DATA_WIDTH-1], x} + (DATA_WIDTH+1)'(1)) >> 1);
`else
        return x;
`endif
    endfunction

    // First-half storage carries no reset; contents are refilled before any read.
    always_ff @(posedge clk) begin
        if (sof_take) begin
            mem_re[0] <= real_in;
            mem_im[0] <= imag_in;
        end else if (fill_take) begin
            mem_re[cnt] <= real_in;
            mem_im[cnt] <= imag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            real_out0 <= '0;
            imag_out0 <= '0;
            real_out1 <= '0;
            imag_out1 <= '0;
            out_idx   <= '0;
            frame_err <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (sof_take) begin
                frame_err <= (state != FILL) || (cnt != '0);
                state     <= FILL;
                cnt       <= IDX_W'(1);
            end else if (fill_take) begin
                cnt <= cnt + IDX_W'(1);
                if (cnt == LAST)
                    state <= PAIR;
            end else if (pair_take) begin
                real_out0 <= scale(mem_re[cnt]);
                imag_out0 <= scale(mem_im[cnt]);
                real_out1 <= scale(real_in);
                imag_out1 <= scale(imag_in);
                out_idx   <= cnt;
                out_valid <= 1'b1;
                cnt       <= cnt + IDX_W'(1);
                if (cnt == LAST)
                    state <= FILL;
            end
        end
    end

endmodule

// File: tb/tb_fft_pair_buffer.sv
// Directed self-checking bench for fft_pair_buffer (DEPTH=4, DATA_WIDTH=16).
module tb_fft_pair_buffer;

    localparam int DW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] real_in;
    logic [DW-1:0] imag_in;
    logic          out_valid;
    logic [DW-1:0] real_out0;
    logic [DW-1:0] imag_out0;
    logic [DW-1:0] real_out1;
    logic [DW-1:0] imag_out1;
    logic [1:0]    out_idx;
    logic          frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int dv [4];

    fft_pair_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .out_valid (out_valid),
        .real_out0 (real_out0),
        .imag_out0 (imag_out0),
        .real_out1 (real_out1),
        .imag_out1 (imag_out1),
        .out_idx   (out_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic int sc(input int x);
`ifdef FFT_PAIR_BUF_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic v, input logic s, input logic e, input int r, input int i);
        in_valid = v;
        in_sof   = s;
        en       = e;
        real_in  = DW'(r);
        imag_in  = DW'(i);
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input int r0, input int i0,
                              input int r1, input int i1, input int idx);
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".re0"}, int'($signed(real_out0)), sc(r0));
        check({tag, ".im0"}, int'($signed(imag_out0)), sc(i0));
        check({tag, ".re1"}, int'($signed(real_out1)), sc(r1));
        check({tag, ".im1"}, int'($signed(imag_out1)), sc(i1));
        check({tag, ".idx"}, int'(out_idx), idx);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, int'(out_valid), 0);
        check({tag, ".re0"}, int'(real_out0), 0);
        check({tag, ".im0"}, int'(imag_out0), 0);
        check({tag, ".re1"}, int'(real_out1), 0);
        check({tag, ".im1"}, int'(imag_out1), 0);
        check({tag, ".idx"}, int'(out_idx), 0);
        check({tag, ".ferr"}, int'(frame_err), 0);
    endtask

    initial begin
        dv = '{3, -3, 32767, -32768};
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        real_in = '0; imag_in = '0;
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // A: continuous stream, imag = -real
        for (int k = 0; k < 2*D; k++) begin
            step(1'b1, 1'b0, 1'b1, k, -k);
            if (k < D) check("A.fill_valid", int'(out_valid), 0);
            else       check_pair("A.pair", k-D, -(k-D), k, -k, k-D);
            check("A.ferr", int'(frame_err), 0);
        end
        step(1'b0, 1'b0, 1'b1, 0, 0);
        check("A.idle_valid", int'(out_valid), 0);
        check("A.idle_hold", int'($signed(real_out1)), sc(7));

        // B: gaps every other cycle, en low for 3 cycles mid-PAIR (with junk + sof)
        for (int k = 0; k < 2*D; k++) begin
            step(1'b1, 1'b0, 1'b1, 10+k, 100+k);
            if (k < D) check("B.fill_valid", int'(out_valid), 0);
            else       check_pair("B.pair", 10+k-D, 100+k-D, 10+k, 100+k, k-D);
            if (k == 5) begin
                repeat (3) begin
                    step(1'b1, 1'b1, 1'b0, 999, 999);
                    check_pair("B.frozen", 11, 101, 15, 105, 1);
                    check("B.frozen_ferr", int'(frame_err), 0);
                end
            end
            step(1'b0, 1'b0, 1'b1, 0, 0);
            check("B.gap_valid", int'(out_valid), 0);
        end

        // C: sof on 3rd sample of a frame
        step(1'b1, 1'b0, 1'b1, 20, -20);
        step(1'b1, 1'b0, 1'b1, 21, -21);
        check("C.pre_ferr", int'(frame_err), 0);
        step(1'b1, 1'b1, 1'b1, 30, -30);
        check("C.ferr_pulse", int'(frame_err), 1);
        check("C.sof_valid", int'(out_valid), 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        check("C.ferr_hold", int'(frame_err), 1);
        step(1'b1, 1'b0, 1'b1, 31, -31);
        check("C.ferr_clear", int'(frame_err), 0);
        step(1'b1, 1'b0, 1'b1, 32, -32);
        step(1'b1, 1'b0, 1'b1, 33, -33);
        check("C.fill_valid", int'(out_valid), 0);
        for (int j = 0; j < D; j++) begin
            step(1'b1, 1'b0, 1'b1, 34+j, -(34+j));
            check_pair("C.pair", 30+j, -(30+j), 34+j, -(34+j), j);
            check("C.ferr_once", int'(frame_err), 0);
        end

        // D: full-scale values, sof at frame start (normal case)
        for (int k = 0; k < 2*D; k++) begin
            if (k < D) step(1'b1, k == 0, 1'b1, dv[k], dv[3-k]);
            else       step(1'b1, 1'b0, 1'b1, dv[3-(k-D)], dv[k-D]);
            check("D.ferr", int'(frame_err), 0);
            if (k >= D)
                check_pair("D.pair", dv[k-D], dv[3-(k-D)], dv[3-(k-D)], dv[k-D], k-D);
        end

        // E: async reset mid-frame, then a fresh frame
        step(1'b1, 1'b0, 1'b1, 40, 40);
        step(1'b1, 1'b0, 1'b1, 41, 41);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("E.rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2*D; k++) begin
            step(1'b1, 1'b0, 1'b1, 50+k, 60+k);
            if (k < D) check("E.fill_valid", int'(out_valid), 0);
            else       check_pair("E.pair", 50+k-D, 60+k-D, 50+k, 60+k, k-D);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
